// File: rtl/serial_adder_if.sv
// Request/response bundle for the bit-serial adder: operands and start in,
// status pulses and the registered result out.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first, WIDTH
// cycles per addition, with the result published on a one-cycle done pulse.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic             carry;
   logic [CW-1:0]    count;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             bit_sum;
   logic             bit_carry;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      bit_sum   = a_reg[0] ^ b_reg[0] ^ carry;
      bit_carry = (a_reg[0] & b_reg[0]) | (b_reg[0] & carry) | (a_reg[0] & carry);
      res_next  = {bit_sum, res_reg[WIDTH-1:1]};
   end

   // sum/cout are only rewritten on the final SHIFT edge, so the previous
   // result stays visible while the next addition is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         carry   <= 1'b0;
         count   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_reg  <= bus.a;
                  b_reg  <= bus.b;
                  carry  <= bus.cin;
                  count  <= '0;
                  busy_q <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               res_reg <= res_next;
               a_reg   <= a_reg >> 1;
               b_reg   <= b_reg >> 1;
               carry   <= bit_carry;
               count   <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  sum_q  <= res_next;
                  cout_q <= bit_carry;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues a+b+cin and the done
// cycle for each accepted start; a negedge monitor checks every output.
module tb_serial_adder;
   localparam int W = 8;

   typedef struct {
      logic [W:0] res;
      int         doneCyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   compared;
   int   mismatched;
   int   acceptCount;
   int   doneSeen;
   bit   checking;
   logic [W:0] lastRes;
   exp_t sb[$];

   serial_adder_if #(.WIDTH(W)) bus();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Expected busy/done come from the oldest queued transaction's done cycle.
   always @(negedge clk) begin
      logic       expBusy;
      logic       expDone;
      logic [W:0] expRes;
      if (checking) begin
         expBusy = 1'b0;
         expDone = 1'b0;
         expRes  = lastRes;
         if (sb.size() > 0) begin
            if (cyc >= sb[0].doneCyc - W && cyc < sb[0].doneCyc) expBusy = 1'b1;
            if (cyc >= sb[0].doneCyc) begin
               expDone = 1'b1;
               expRes  = sb[0].res;
            end
         end
         if (bus.done === 1'b1) doneSeen++;
         checkOutput("busy", 64'(bus.busy), 64'(expBusy));
         checkOutput("done", 64'(bus.done), 64'(expDone));
         checkOutput("sum",  64'(bus.sum),  64'(expRes[W-1:0]));
         checkOutput("cout", 64'(bus.cout), 64'(expRes[W]));
         if (bus.busy === 1'b1 && bus.done === 1'b1)
            checkOutput("busy_and_done", 64'(1), 64'(0));
         if (expDone) begin
            lastRes = expRes;
            void'(sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      step();
      sb.delete();
      lastRes   = '0;
      checking  = 1'b1;
      rst       = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic acceptOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      exp_t e;
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      step();
      e.res     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.doneCyc = cyc + W;
      sb.push_back(e);
   endtask

   // mode 0: start low while busy; 1: start held high with 0xFF operands;
   // 2: random junk on start/a/b/cin until the DUT is idle again.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input int mode);
      acceptOp(a, b, cin);
      acceptCount++;
      for (int i = 0; i <= W; i++) begin
         case (mode)
            1: begin
               bus.start = 1'b1;
               bus.a     = '1;
               bus.b     = '1;
               bus.cin   = 1'b1;
            end
            2: begin
               bus.start = 1'($urandom);
               bus.a     = W'($urandom);
               bus.b     = W'($urandom);
               bus.cin   = 1'($urandom);
            end
            default: bus.start = 1'b0;
         endcase
         step();
      end
      bus.start = 1'b0;
   endtask

   task automatic applyAbort(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input int n);
      acceptOp(a, b, cin);
      bus.start = 1'b0;
      repeat (n) step();
      applyReset();
   endtask

   initial begin
      cyc         = 0;
      compared    = 0;
      mismatched  = 0;
      acceptCount = 0;
      doneSeen    = 0;
      checking    = 1'b0;
      lastRes     = '0;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.a       = '0;
      bus.b       = '0;
      bus.cin     = 1'b0;

      applyReset();
      applyStimulus(8'h00, 8'h00, 1'b0, 0);
      applyStimulus(8'hFF, 8'h01, 1'b0, 0);
      applyStimulus(8'hA5, 8'h5A, 1'b1, 0);
      applyStimulus(8'h3C, 8'h42, 1'b0, 0);
      applyStimulus(8'h10, 8'h20, 1'b0, 1);
      applyStimulus(8'h01, 8'h01, 1'b0, 0);
      applyAbort(8'hF0, 8'h0F, 1'b1, 4);
      applyStimulus(8'h01, 8'h02, 1'b0, 0);
      applyStimulus(8'h80, 8'h80, 1'b0, 0);
      for (int i = 0; i < 200; i++)
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 2);
      repeat (4) step();

      checkOutput("done_count", 64'(doneSeen), 64'(acceptCount));
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepting edge.
REQ-008 Port: busy  output  1  high while bits are being processed (SHIFT state).
REQ-009 Port: done  output  1  one-cycle pulse; result valid on sum/cout.
REQ-010 Port: sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 Port: cout  output  1  registered carry-out of the addition.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1, the block SHALL load a, b, cin into internal shift/carry registers, clear the bit counter, and go to SHIFT.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-015 In SHIFT, each cycle SHALL compute one full-adder bit, LSB first: s = ai^bi^c, c' = ai&bi | bi&c | ai&c.
REQ-016 In SHIFT, each cycle SHALL shift s into the MSB of the internal result register, shift both operand registers right by one, and update the carry register with c'.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of width clog2(WIDTH)+1.
REQ-018 After the last SHIFT cycle, the block SHALL enter DONE.
REQ-019 On entry to DONE, the block SHALL copy the internal result to sum and the final carry to cout.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-021 Latency: start accepted at edge k -> busy=1 in cycles k+1..k+WIDTH, done=1 in cycle k+WIDTH+1 only.
REQ-022 busy SHALL be 1 only in SHIFT; done SHALL be 1 only in DONE; busy and done SHALL never be 1 together.
REQ-023 start SHALL be ignored in SHIFT and DONE; operands and in-flight state SHALL NOT change.
REQ-024 A start asserted in the cycle done=1 SHALL be ignored; the earliest accept is the cycle after done, in IDLE.
REQ-025 sum and cout SHALL hold the last completed result until the next DONE, including during a subsequent SHIFT.
REQ-026 a, b and cin SHALL be don't-care except on the accepting edge.

Reset
REQ-027 With rst=1 at an edge, the block SHALL enter IDLE and clear busy=0, done=0, sum=0, cout=0, counter=0, and all internal registers to 0.
REQ-028 rst SHALL take priority over start; start in the same cycle as rst SHALL be ignored.
REQ-029 rst asserted in SHIFT or DONE SHALL abort the operation, produce no done pulse, and leave sum/cout=0.
REQ-030 After rst deasserts, the first edge with start=1 in IDLE SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031 Reset, then start at edge 0 with a=0x00, b=0x00, cin=0 -> busy high cycles 1..8; done pulse cycle 9; sum=0x00, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> at done: sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
REQ-033 Start a=0x10, b=0x20; pulse start with a=0xFF, b=0xFF at cycle 4 and again in the done cycle -> both ignored; sum=0x30, cout=0; exactly one done pulse.
REQ-034 Complete 0x01+0x01 (sum=0x02); start 0xF0+0x0F, cin=1; assert rst at cycle 5 -> no done pulse, busy=0, sum=0x00, cout=0 next cycle; start 0x01+0x02 after rst -> sum=0x03 at cycle 9 after accept.
REQ-035 Start accepted in the cycle after done for 0x80+0x80 -> sum=0x00, cout=1 9 cycles later; previous sum held until then.
REQ-036 Run 200 random {a, b, cin} back-to-back -> each done shows {cout, sum} == a+b+cin; done count equals accepted starts.
